// File: rtl/processador_param.sv
// Parameterised multi-cycle processor: FETCH with valid handshake, EX1..EX3 execution,
// zero/carry flags, conditional branches and a HALT state left only through reset.
module processador_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] iin,
    input  logic                  iin_valid,
    output logic [DATA_WIDTH-1:0] bus,
    output logic [ADDR_WIDTH-1:0] endereco,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  halted
);
    localparam int unsigned RB    = $clog2(NUM_REGS);
    localparam int unsigned IMM_W = DATA_WIDTH - 4 - RB;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EX1   = 3'd1;
    localparam logic [2:0] S_EX2   = 3'd2;
    localparam logic [2:0] S_EX3   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_BZ   = 4'd6;
    localparam logic [3:0] OP_BNZ  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_g;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_z;
    logic                  r_c;

    logic [3:0]            w_op;
    logic [RB-1:0]         w_rx;
    logic [RB-1:0]         w_ry;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_bus;
    logic [DATA_WIDTH:0]   w_alu;
    logic                  w_ld_ir;
    logic                  w_ld_rx;
    logic                  w_ld_a;
    logic                  w_ld_g;
    logic                  w_ld_pc;

    // Field decode always works on the latched instruction, never on iin
    assign w_op  = r_ir[DATA_WIDTH-1 -: 4];
    assign w_rx  = r_ir[DATA_WIDTH-5 -: RB];
    assign w_ry  = r_ir[DATA_WIDTH-5-RB -: RB];
    assign w_imm = DATA_WIDTH'(r_ir[IMM_W-1:0]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, bus source selection and load enables
    always_comb begin
        w_next  = r_state;
        w_bus   = '0;
        w_ld_ir = 1'b0;
        w_ld_rx = 1'b0;
        w_ld_a  = 1'b0;
        w_ld_g  = 1'b0;
        w_ld_pc = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (iin_valid) begin
                    w_ld_ir = 1'b1;
                    w_next  = S_EX1;
                end
            end
            S_EX1: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_MV: begin
                        w_bus   = r_regs[w_ry];
                        w_ld_rx = 1'b1;
                    end
                    OP_MVI: begin
                        w_bus   = w_imm;
                        w_ld_rx = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_bus  = r_regs[w_rx];
                        w_ld_a = 1'b1;
                        w_next = S_EX2;
                    end
                    OP_JMP: begin
                        w_bus   = r_regs[w_ry];
                        w_ld_pc = 1'b1;
                    end
                    OP_BZ: begin
                        if (r_z) begin
                            w_bus   = r_regs[w_ry];
                            w_ld_pc = 1'b1;
                        end
                    end
                    OP_BNZ: begin
                        if (!r_z) begin
                            w_bus   = r_regs[w_ry];
                            w_ld_pc = 1'b1;
                        end
                    end
                    OP_HALT: w_next = S_HALT;
                    default: w_next = S_FETCH;
                endcase
            end
            S_EX2: begin
                w_bus  = r_regs[w_ry];
                w_ld_g = 1'b1;
                w_next = S_EX3;
            end
            S_EX3: begin
                w_bus   = r_g;
                w_ld_rx = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // ALU with one extra bit: carry out for add, borrow for sub
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = {1'b0, r_a} + {1'b0, w_bus};
            OP_SUB:  w_alu = {1'b0, r_a} - {1'b0, w_bus};
            default: w_alu = {1'b0, r_a & w_bus};
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc <= '0;
            r_ir <= '0;
            r_a  <= '0;
            r_g  <= '0;
            r_z  <= 1'b0;
            r_c  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ld_ir) begin
                r_ir <= iin;
                r_pc <= r_pc + ADDR_WIDTH'(1);
            end else if (w_ld_pc) begin
                r_pc <= ADDR_WIDTH'(w_bus);
            end
            if (w_ld_rx) begin
                r_regs[w_rx] <= w_bus;
            end
            if (w_ld_a) begin
                r_a <= w_bus;
            end
            if (w_ld_g) begin
                r_g <= w_alu[DATA_WIDTH-1:0];
                r_z <= (w_alu[DATA_WIDTH-1:0] == '0);
                if (w_op != OP_AND) begin
                    r_c <= w_alu[DATA_WIDTH];
                end
            end
        end
    end

    assign bus      = w_bus;
    assign endereco = r_pc;
    assign flag_z   = r_z;
    assign flag_c   = r_c;
    assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_processador_param.sv
// Directed bench for processador_param: default 16-bit core plus an 8-bit/4-reg/4-bit-PC variant.
module tb_processador_param;
    logic        clock;
    logic        resetn;
    logic [15:0] iin;
    logic        iin_valid;
    logic [15:0] bus;
    logic [15:0] endereco;
    logic        flag_z;
    logic        flag_c;
    logic        halted;

    logic        resetn2;
    logic [7:0]  iin2;
    logic        iin_valid2;
    logic [7:0]  bus2;
    logic [3:0]  endereco2;
    logic        flag_z2;
    logic        flag_c2;
    logic        halted2;

    int          n_chk;
    int          n_fail;
    logic [15:0] pc_exp;
    logic [3:0]  pc2_exp;

    processador_param dut (
        .clock     (clock),
        .resetn    (resetn),
        .iin       (iin),
        .iin_valid (iin_valid),
        .bus       (bus),
        .endereco  (endereco),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .halted    (halted)
    );

    processador_param #(.DATA_WIDTH(8), .NUM_REGS(4), .ADDR_WIDTH(4)) dut2 (
        .clock     (clock),
        .resetn    (resetn2),
        .iin       (iin2),
        .iin_valid (iin_valid2),
        .bus       (bus2),
        .endereco  (endereco2),
        .flag_z    (flag_z2),
        .flag_c    (flag_c2),
        .halted    (halted2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one word for a single cycle; returns sampled in EX1
    task automatic fetch(input logic [15:0] w);
        iin       = w;
        iin_valid = 1'b1;
        step();
        iin_valid = 1'b0;
        pc_exp    = pc_exp + 16'd1;
    endtask

    task automatic fetch2(input logic [7:0] w);
        iin2       = w;
        iin_valid2 = 1'b1;
        step();
        iin_valid2 = 1'b0;
        pc2_exp    = pc2_exp + 4'd1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; pc_exp = '0; pc2_exp = '0;
        resetn = 1'b1; resetn2 = 1'b1;
        iin = '0; iin_valid = 1'b0; iin2 = '0; iin_valid2 = 1'b0;
        #1;
        resetn = 1'b0; resetn2 = 1'b0;
        #1;
        check("rst_pc",     32'(endereco), 32'h0);
        check("rst_bus",    32'(bus),      32'h0);
        check("rst_z",      32'(flag_z),   32'h0);
        check("rst_c",      32'(flag_c),   32'h0);
        check("rst_halted", 32'(halted),   32'h0);
        #10;
        resetn = 1'b1;

        repeat (5) step();
        check("stall_pc",  32'(endereco), 32'h0);
        check("stall_bus", 32'(bus),      32'h0);

        fetch(16'h11FF);
        check("mvi_r0_bus", 32'(bus),      32'h01FF);
        check("pc_inc",     32'(endereco), 32'h1);
        step();
        check("mvi_r0",    32'(dut.r_regs[0]), 32'h01FF);
        check("fetch_bus", 32'(bus),           32'h0);

        fetch(16'h1405); step();
        check("mvi_r2", 32'(dut.r_regs[2]), 32'h0005);
        fetch(16'h0680);
        check("mv_bus", 32'(bus), 32'h0005);
        step();
        check("mv_r3", 32'(dut.r_regs[3]), 32'h0005);
        check("mv_pc", 32'(endereco), 32'(pc_exp));

        // rx == ry: A latched before G, so r3 doubles
        fetch(16'h26C0); step(); step(); step();
        check("add_self_r3", 32'(dut.r_regs[3]), 32'h000A);

        fetch(16'h1200); step();
        fetch(16'h1401); step();
        fetch(16'h3280);
        check("sub_ex1_bus", 32'(bus), 32'h0000);
        step();
        check("sub_ex2_bus", 32'(bus), 32'h0001);
        step();
        check("sub_ex3_bus",   32'(bus),           32'hFFFF);
        check("sub_r1_before", 32'(dut.r_regs[1]), 32'h0000);
        check("sub_c",         32'(flag_c),        32'h1);
        check("sub_z",         32'(flag_z),        32'h0);
        step();
        check("sub_r1", 32'(dut.r_regs[1]), 32'hFFFF);

        fetch(16'h2280); step(); step(); step();
        check("add_r1", 32'(dut.r_regs[1]), 32'h0000);
        check("add_c",  32'(flag_c),        32'h1);
        check("add_z",  32'(flag_z),        32'h1);

        fetch(16'h1820); step();
        check("mvi_r4",      32'(dut.r_regs[4]), 32'h0020);
        check("mvi_keeps_z", 32'(flag_z),        32'h1);

        fetch(16'h6100); step();
        pc_exp = 16'h0020;
        check("bz_taken", 32'(endereco), 32'(pc_exp));

        fetch(16'h4900); step(); step(); step();
        check("and_r4",     32'(dut.r_regs[4]), 32'h0020);
        check("and_z",      32'(flag_z),        32'h0);
        check("and_keep_c", 32'(flag_c),        32'h1);

        fetch(16'h6100);
        check("bz_nt_bus", 32'(bus), 32'h0);
        step();
        check("bz_not_taken", 32'(endereco),        32'(pc_exp));
        check("bz_nt_r4",     32'(dut.r_regs[4]),   32'h0020);

        fetch(16'h7100); step();
        pc_exp = 16'h0020;
        check("bnz_taken", 32'(endereco), 32'(pc_exp));

        fetch(16'h3B40); step(); step(); step();
        check("sub0_z", 32'(flag_z), 32'h1);
        check("sub0_c", 32'(flag_c), 32'h0);

        fetch(16'h7100);
        check("bnz_nt_bus", 32'(bus), 32'h0);
        step();
        check("bnz_not_taken", 32'(endereco), 32'(pc_exp));

        fetch(16'h8000);
        check("halt_ex1", 32'(halted), 32'h0);
        step();
        check("halt_state", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            iin       = 16'($urandom);
            iin_valid = 1'b1;
            step();
            check("halt_pc_hold", 32'(endereco), 32'(pc_exp));
        end
        iin_valid = 1'b0;
        check("halt_still", 32'(halted),         32'h1);
        check("halt_r2",    32'(dut.r_regs[2]),  32'h0001);
        check("halt_bus",   32'(bus),            32'h0);

        #2; resetn = 1'b0; #2; resetn = 1'b1;
        pc_exp = '0;
        step();
        check("unhalt", 32'(halted), 32'h0);
        fetch(16'h1207); step();
        fetch(16'h2240); step();
        check("ex2_bus", 32'(bus), 32'h0007);
        #2; resetn = 1'b0; #1;
        check("midrst_bus",    32'(bus),           32'h0);
        check("midrst_pc",     32'(endereco),      32'h0);
        check("midrst_r1",     32'(dut.r_regs[1]), 32'h0);
        check("midrst_z",      32'(flag_z),        32'h0);
        check("midrst_c",      32'(flag_c),        32'h0);
        check("midrst_halted", 32'(halted),        32'h0);
        #3; resetn = 1'b1;
        step();
        check("post_rst_pc",  32'(endereco), 32'h0);
        check("post_rst_bus", 32'(bus),      32'h0);

        resetn2 = 1'b1;
        step();
        fetch2(8'h13);
        check("v_mvi_bus", 32'(bus2), 32'h03);
        step();
        check("v_r0_3", 32'(dut2.r_regs[0]), 32'h03);
        fetch2(8'h20); step(); step(); step();
        check("v_r0_6", 32'(dut2.r_regs[0]), 32'h06);
        for (int i = 0; i < 13; i++) begin
            fetch2(8'h90);
            step();
        end
        check("v_pc_15", 32'(endereco2), 32'hF);
        fetch2(8'h90);
        check("v_pc_wrap", 32'(endereco2), 32'h0);
        check("v_pc_model", 32'(endereco2), 32'(pc2_exp));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/processador_param.md
Name: processador_param

Overview:
Parameterised multi-cycle processor. It replaces the fixed 16-bit, 8-register core and generalises data width, register count and address width. Over the previous core it adds:
- an instruction-fetch handshake (iin_valid), so slow instruction memory can stall the core
- zero and carry flags
- conditional branches
- a HALT state

It sits at the top of the datapath and drives bus and endereco to the memory and debug logic.

Parameters:
DATA_WIDTH, 16, width of registers, bus and instruction word; must be >= 5 + 2*RB, where RB = log2(NUM_REGS)
NUM_REGS, 8, number of general registers; power of 2, range 2..16
ADDR_WIDTH, 16, width of program counter and endereco

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
iin  input  DATA_WIDTH  instruction word at address endereco
iin_valid  input  1  iin holds a valid word this cycle
bus  output  DATA_WIDTH  internal bus value, combinational from the selected source
endereco  output  ADDR_WIDTH  current PC (instruction fetch address)
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag
halted  output  1  high while in HALT

Behaviour:
- Reset (resetn=0, asynchronous): PC=0, all registers, A, G, IR, flag_z and flag_c = 0; state=FETCH; halted=0; bus=0. Release is sampled on the next rising edge.
- bus is 0 whenever no source is selected (FETCH, HALT).
- Instruction fields:
  - opcode = iin[DW-1:DW-4]
  - rx = next RB bits
  - ry = next RB bits
  - imm = iin[DW-5-RB:0], zero-extended to DW
- States: FETCH, EX1, EX2, EX3, HALT.
- FETCH:
  - endereco=PC.
  - If iin_valid=1: IR<=iin, PC<=PC+1 (wraps modulo 2^ADDR_WIDTH), go to EX1.
  - Otherwise stay in FETCH; nothing else changes.
- EX1 by opcode:
  - 0 mv: bus=ry; rx<=bus; go to FETCH.
  - 1 mvi: bus=imm; rx<=bus; go to FETCH.
  - 2 add, 3 sub, 4 and: bus=rx; A<=bus; go to EX2.
  - 5 jmp: bus=ry; PC<=bus[ADDR_WIDTH-1:0] (zero-extend if narrower); go to FETCH.
  - 6 bz: if flag_z=1, behave as jmp; else bus=0, no write; go to FETCH.
  - 7 bnz: same as bz with the condition flag_z=0.
  - 8 halt: go to HALT.
  - 9..15: nop; go to FETCH.
- EX2: bus=ry; G<=A op bus; go to EX3.
  - add: flag_c = carry out of bit DW-1.
  - sub: flag_c = borrow, i.e. 1 when A<ry unsigned.
  - and: flag_c is unchanged.
  - flag_z = (result==0) for all three ops.
- EX3: bus=G; rx<=bus; go to FETCH.
- Latency: mv/mvi/jmp/branches/nop take 2 cycles; ALU ops take 4 cycles; halt takes 2 cycles to reach HALT. Each count excludes FETCH stall cycles.
- rx==ry is legal: A is captured before G is computed, so add r1,r1 doubles r1.
- Flags change only in EX2 of add, sub or and. mv and mvi do not affect flags.
- HALT: halted=1; PC and registers hold; iin and iin_valid are ignored; the only exit is reset.
- Reset asserted in any state aborts the instruction immediately. No partial register write survives after the reset value.

Test Plan:
For DW=16, NUM_REGS=8, the fields are: opcode [15:12], rx [11:9], ry [8:6], imm [8:0].

- Reset/fetch stall: resetn low, then high, with iin_valid=0 for 5 cycles -> endereco=0, bus=0, state stays FETCH. Then iin=0x11FF with valid -> next cycle r0=0x01FF, and endereco becomes 1 after the fetch.
- Move: mvi r2,#5 (0x1405), then mv r3,r2 (0x0680) -> r3=0x0005; each instruction takes 2 cycles after accept.
- Borrow/carry: mvi r1,#0 (0x1200), mvi r2,#1 (0x1401), sub r1,r2 (0x3280) -> r1=0xFFFF, C=1, Z=0. Then add r1,r2 (0x2280) -> r1=0x0000, C=1, Z=1, with the write in EX3, 4 cycles after accept.
- Branches: with Z=1, r4=0x0020, bz r4 (0x6100) -> endereco=0x0020. With Z=0, the same word -> endereco=PC+1 and no register changes. bnz checked with the opposite outcomes.
- Halt and reset mid-op: halt (0x8000) -> halted=1, and endereco stays fixed for 20 cycles with valid words presented. Then pulse resetn low during EX2 of an add -> all outputs return to reset values with no clock edge needed.
- Variant DW=8, NUM_REGS=4, ADDR_WIDTH=4 (fields: opcode [7:4], rx [3:2], ry [1:0], imm [1:0]):
  - mvi r0,#3 (0x13), add r0,r0 (0x20) -> r0=0x06.
  - PC wraps from 15 to 0 after 16 fetches.
